// File: rtl/pipe_pkg.sv
// Shared pipeline types: the ID/EX control bundle, its bubble value and ALUOp classes.
// No logic and no latency; the bubble is all zeros so that a squashed slot has no side effects.
package pipe_pkg;

  localparam int CTRL_W = 8;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic       regDst;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {
    IDLE,
    HOLD
  } stallState_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare between the load in EX and the source registers of the instruction in ID.
// Purely combinational, zero latency; it only detects the hazard and never applies backpressure.
module load_use_detect (
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  output logic       hazard
);

  // $0 is hardwired to zero, so a load into it can never be a real dependency.
  assign hazard = exMemRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall FSM; 1-cycle register latency.
// Backpressure: while Stall=1, PCWrite/IF_ID_Write drop and bubbles are loaded; Flush overrides.
module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRd,
  input  logic        ID_RegWrite,
  input  logic        ID_MemtoReg,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_ALUSrc,
  input  logic        ID_RegDst,
  input  logic [1:0]  ID_ALUOp,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_SignExtImm,
  input  logic [31:0] ID_PCPlus4,
  input  logic        Flush,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        Stall,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemtoReg,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_RegDst,
  output logic [1:0]  ID_EX_ALUOp,
  output logic [31:0] ID_EX_ReadData1,
  output logic [31:0] ID_EX_ReadData2,
  output logic [31:0] ID_EX_SignExtImm,
  output logic [31:0] ID_EX_PCPlus4,
  output logic [4:0]  ID_EX_RegisterRs,
  output logic [4:0]  ID_EX_RegisterRt,
  output logic [4:0]  ID_EX_RegisterRd,
  output logic [15:0] StallCount
);

  localparam logic [2:0] REM_INIT = 3'(STALL_CYCLES - 1);

  stallState_t state;
  logic [2:0]  remaining;
  ctrl_t       idCtrl;
  ctrl_t       exCtrl;
  logic        hazard;

  assign idCtrl = {ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst, ID_ALUOp};

  assign ID_EX_RegWrite = exCtrl.regWrite;
  assign ID_EX_MemtoReg = exCtrl.memtoReg;
  assign ID_EX_MemRead  = exCtrl.memRead;
  assign ID_EX_MemWrite = exCtrl.memWrite;
  assign ID_EX_ALUSrc   = exCtrl.aluSrc;
  assign ID_EX_RegDst   = exCtrl.regDst;
  assign ID_EX_ALUOp    = exCtrl.aluOp;

  load_use_detect uDetect (
    .exMemRead (exCtrl.memRead),
    .exRt      (ID_EX_RegisterRt),
    .idRs      (IF_ID_RegisterRs),
    .idRt      (IF_ID_RegisterRt),
    .hazard    (hazard)
  );

  // The first stall cycle comes straight from the compare; HOLD only covers the extra ones.
  assign Stall       = !Flush && ((state == HOLD) || hazard);
  assign PCWrite     = !Stall;
  assign IF_ID_Write = !Stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      remaining        <= '0;
      exCtrl           <= CTRL_BUBBLE;
      ID_EX_ReadData1  <= '0;
      ID_EX_ReadData2  <= '0;
      ID_EX_SignExtImm <= '0;
      ID_EX_PCPlus4    <= '0;
      ID_EX_RegisterRs <= '0;
      ID_EX_RegisterRt <= '0;
      ID_EX_RegisterRd <= '0;
      StallCount       <= '0;
    end else begin
      exCtrl           <= (Stall || Flush) ? CTRL_BUBBLE : idCtrl;
      ID_EX_ReadData1  <= ID_ReadData1;
      ID_EX_ReadData2  <= ID_ReadData2;
      ID_EX_SignExtImm <= ID_SignExtImm;
      ID_EX_PCPlus4    <= ID_PCPlus4;
      ID_EX_RegisterRs <= IF_ID_RegisterRs;
      ID_EX_RegisterRt <= IF_ID_RegisterRt;
      ID_EX_RegisterRd <= IF_ID_RegisterRd;

      if (Stall && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end

      if (Flush) begin
        state     <= IDLE;
        remaining <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (Stall && (STALL_CYCLES > 1)) begin
              state     <= HOLD;
              remaining <= REM_INIT;
            end
          end
          HOLD: begin
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
